// File: rtl/uc_jogao_da_velha_pkg.sv
// Package shared by the ultimate tic-tac-toe control unit and its datapath.
// Holds the 5-bit state codes. The 7-segment debug decoder in the datapath
// shows these same codes, so both sides must agree on every value.
package jogao_pkg;

  localparam int ESTADO_W = 5;

  typedef enum logic [ESTADO_W-1:0] {
    E_INICIAL        = 5'd0,
    E_PREPARA        = 5'd1,
    E_ESPERA_MACRO   = 5'd2,
    E_REGISTRA_MACRO = 5'd3,
    E_LE_MACRO       = 5'd4,
    E_VALIDA_MACRO   = 5'd5,
    E_ESPERA_MICRO   = 5'd6,
    E_REGISTRA_MICRO = 5'd7,
    E_LE_MICRO       = 5'd8,
    E_VALIDA_MICRO   = 5'd9,
    E_ESCREVE_MICRO  = 5'd10,
    E_LE_RES_MICRO   = 5'd11,
    E_VERIFICA_MICRO = 5'd12,
    E_ESCREVE_MACRO  = 5'd13,
    E_LE_RES_MACRO   = 5'd14,
    E_VERIFICA_MACRO = 5'd15,
    E_TROCA_JOGADOR  = 5'd16,
    E_FIM            = 5'd17
  } estado_t;

  // States that wait for the board memory read latency to elapse.
  function automatic logic is_leitura(estado_t e);
    return (e == E_LE_MACRO) || (e == E_LE_MICRO) ||
           (e == E_LE_RES_MICRO) || (e == E_LE_RES_MACRO);
  endfunction

endpackage

// File: rtl/uc_jogao_da_velha_if.sv
// Interface between the control unit and the datapath.
//   Status (datapath -> UC): iniciar, tem_jogada, macro_valida, micro_valida,
//     ganhou_micro, micro_cheio, ganhou_macro, macro_cheio, proximo_livre
//   Commands (UC -> datapath): zera, registra_macro, registra_micro,
//     escreve_micro, escreve_macro, troca_jogador, jogar_macro, jogar_micro,
//     pronto, db_estado[4:0]
// master = control unit, slave = datapath.
interface uc_jogao_da_velha_if import jogao_pkg::*;;

  logic                iniciar;
  logic                tem_jogada;
  logic                macro_valida;
  logic                micro_valida;
  logic                ganhou_micro;
  logic                micro_cheio;
  logic                ganhou_macro;
  logic                macro_cheio;
  logic                proximo_livre;

  logic                zera;
  logic                registra_macro;
  logic                registra_micro;
  logic                escreve_micro;
  logic                escreve_macro;
  logic                troca_jogador;
  logic                jogar_macro;
  logic                jogar_micro;
  logic                pronto;
  logic [ESTADO_W-1:0] db_estado;

  modport master (
    input  iniciar, tem_jogada, macro_valida, micro_valida, ganhou_micro,
           micro_cheio, ganhou_macro, macro_cheio, proximo_livre,
    output zera, registra_macro, registra_micro, escreve_micro, escreve_macro,
           troca_jogador, jogar_macro, jogar_micro, pronto, db_estado
  );

  modport slave (
    output iniciar, tem_jogada, macro_valida, micro_valida, ganhou_micro,
           micro_cheio, ganhou_macro, macro_cheio, proximo_livre,
    input  zera, registra_macro, registra_micro, escreve_micro, escreve_macro,
           troca_jogador, jogar_macro, jogar_micro, pronto, db_estado
  );

endinterface

// File: rtl/uc_jogao_da_velha.sv
// Control unit (Moore FSM) for ultimate tic-tac-toe.
// Collects macro then micro moves, validates them against the board,
// commands board writes and player swaps, and signals the end of the game.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high; returns to INICIAL
//   uc     - status in / command out bundle (see uc_jogao_da_velha_if)
// Parameter MEM_LAT (>=1): board memory read latency; each LE_* state is held
// for exactly MEM_LAT clocks.
module uc_jogao_da_velha
  import jogao_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  uc_jogao_da_velha_if.master  uc
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fim_espera;

  assign fim_espera = (cnt_q == CNT_W'(MEM_LAT - 1));

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= E_INICIAL;
      cnt_q    <= '0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    estado_d          = estado_q;
    uc.zera           = 1'b0;
    uc.registra_macro = 1'b0;
    uc.registra_micro = 1'b0;
    uc.escreve_micro  = 1'b0;
    uc.escreve_macro  = 1'b0;
    uc.troca_jogador  = 1'b0;
    uc.jogar_macro    = 1'b0;
    uc.jogar_micro    = 1'b0;
    uc.pronto         = 1'b0;

    case (estado_q)
      E_INICIAL:        if (uc.iniciar) estado_d = E_PREPARA;
      E_PREPARA: begin
        uc.zera  = 1'b1;
        estado_d = E_ESPERA_MACRO;
      end
      E_ESPERA_MACRO: begin
        uc.jogar_macro = 1'b1;
        if (uc.tem_jogada) estado_d = E_REGISTRA_MACRO;
      end
      E_REGISTRA_MACRO: begin
        uc.registra_macro = 1'b1;
        estado_d          = E_LE_MACRO;
      end
      E_LE_MACRO:       if (fim_espera) estado_d = E_VALIDA_MACRO;
      E_VALIDA_MACRO:   estado_d = uc.macro_valida ? E_ESPERA_MICRO : E_ESPERA_MACRO;
      E_ESPERA_MICRO: begin
        uc.jogar_micro = 1'b1;
        if (uc.tem_jogada) estado_d = E_REGISTRA_MICRO;
      end
      E_REGISTRA_MICRO: begin
        uc.registra_micro = 1'b1;
        estado_d          = E_LE_MICRO;
      end
      E_LE_MICRO:       if (fim_espera) estado_d = E_VALIDA_MICRO;
      E_VALIDA_MICRO:   estado_d = uc.micro_valida ? E_ESCREVE_MICRO : E_ESPERA_MICRO;
      E_ESCREVE_MICRO: begin
        uc.escreve_micro = 1'b1;
        estado_d         = E_LE_RES_MICRO;
      end
      E_LE_RES_MICRO:   if (fim_espera) estado_d = E_VERIFICA_MICRO;
      // A win and a full cell at once both lead here; the datapath picks the value.
      E_VERIFICA_MICRO: estado_d = (uc.ganhou_micro || uc.micro_cheio) ? E_ESCREVE_MACRO
                                                                       : E_TROCA_JOGADOR;
      E_ESCREVE_MACRO: begin
        uc.escreve_macro = 1'b1;
        estado_d         = E_LE_RES_MACRO;
      end
      E_LE_RES_MACRO:   if (fim_espera) estado_d = E_VERIFICA_MACRO;
      E_VERIFICA_MACRO: estado_d = (uc.ganhou_macro || uc.macro_cheio) ? E_FIM
                                                                       : E_TROCA_JOGADOR;
      // If the macro cell the opponent is sent to is playable, the choice is
      // forced and we go straight to the micro move.
      E_TROCA_JOGADOR: begin
        uc.troca_jogador = 1'b1;
        estado_d         = uc.proximo_livre ? E_ESPERA_MICRO : E_ESPERA_MACRO;
      end
      E_FIM: begin
        uc.pronto = 1'b1;
        if (uc.iniciar) estado_d = E_PREPARA;
      end
      default:          estado_d = E_INICIAL;
    endcase
  end

  // Counter restarts on every entry into a read-wait state and counts while
  // the state is held.
  always_comb begin
    cnt_d = '0;
    if (is_leitura(estado_q) && (estado_d == estado_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  assign uc.db_estado = estado_q;

endmodule

// File: tb/tb_uc_jogao_da_velha.sv
// Self-checking bench for uc_jogao_da_velha. Two instances: MEM_LAT=1 for the
// game flow and MEM_LAT=3 for dwell length and asynchronous reset mid-game.
// Expected state codes are queued when stimulus is applied and popped one per
// clock; expected outputs are derived from the state table.
module tb_uc_jogao_da_velha;

  logic clock;
  logic rst_a, rst_b;
  logic sel;
  logic iniciar, tem_jogada, macro_valida, micro_valida, ganhou_micro;
  logic micro_cheio, ganhou_macro, macro_cheio, proximo_livre;

  int n_checks;
  int n_fail;
  int exp_q[$];

  uc_jogao_da_velha_if bus_a ();
  uc_jogao_da_velha_if bus_b ();

  uc_jogao_da_velha #(.MEM_LAT(1)) dut_a (.clock(clock), .reset(rst_a), .uc(bus_a));
  uc_jogao_da_velha #(.MEM_LAT(3)) dut_b (.clock(clock), .reset(rst_b), .uc(bus_b));

  assign bus_a.iniciar       = iniciar;
  assign bus_a.tem_jogada    = tem_jogada;
  assign bus_a.macro_valida  = macro_valida;
  assign bus_a.micro_valida  = micro_valida;
  assign bus_a.ganhou_micro  = ganhou_micro;
  assign bus_a.micro_cheio   = micro_cheio;
  assign bus_a.ganhou_macro  = ganhou_macro;
  assign bus_a.macro_cheio   = macro_cheio;
  assign bus_a.proximo_livre = proximo_livre;
  assign bus_b.iniciar       = iniciar;
  assign bus_b.tem_jogada    = tem_jogada;
  assign bus_b.macro_valida  = macro_valida;
  assign bus_b.micro_valida  = micro_valida;
  assign bus_b.ganhou_micro  = ganhou_micro;
  assign bus_b.micro_cheio   = micro_cheio;
  assign bus_b.ganhou_macro  = ganhou_macro;
  assign bus_b.macro_cheio   = macro_cheio;
  assign bus_b.proximo_livre = proximo_livre;

  // {zera, reg_macro, reg_micro, esc_micro, esc_macro, troca, jog_macro, jog_micro, pronto}
  logic [8:0] outs_a, outs_b, obs_outs;
  logic [4:0] obs_db;
  assign outs_a = {bus_a.zera, bus_a.registra_macro, bus_a.registra_micro, bus_a.escreve_micro,
                   bus_a.escreve_macro, bus_a.troca_jogador, bus_a.jogar_macro,
                   bus_a.jogar_micro, bus_a.pronto};
  assign outs_b = {bus_b.zera, bus_b.registra_macro, bus_b.registra_micro, bus_b.escreve_micro,
                   bus_b.escreve_macro, bus_b.troca_jogador, bus_b.jogar_macro,
                   bus_b.jogar_micro, bus_b.pronto};
  assign obs_outs = sel ? outs_b : outs_a;
  assign obs_db   = sel ? bus_b.db_estado : bus_a.db_estado;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [8:0] exp_outs(int code);
    case (code)
      1:       return 9'b1_0000_0000;
      2:       return 9'b0_0000_0100;
      3:       return 9'b0_1000_0000;
      6:       return 9'b0_0000_0010;
      7:       return 9'b0_0100_0000;
      10:      return 9'b0_0010_0000;
      13:      return 9'b0_0001_0000;
      16:      return 9'b0_0000_1000;
      17:      return 9'b0_0000_0001;
      default: return 9'b0_0000_0000;
    endcase
  endfunction

  task automatic check(string tag, logic [8:0] obs, logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(int code);
    exp_q.push_back(code);
  endtask

  task automatic push_seq(int first, int last);
    for (int i = first; i <= last; i++) exp_q.push_back(i);
  endtask

  // One pop per clock; pulse-type inputs last exactly one cycle.
  task automatic drain(string tag);
    int e;
    int step;
    step = 0;
    while (exp_q.size() > 0) begin
      @(posedge clock);
      #1;
      tem_jogada = 1'b0;
      iniciar    = 1'b0;
      e = exp_q.pop_front();
      check($sformatf("%s_db%0d", tag, step), {4'b0, obs_db}, 9'(e));
      check($sformatf("%s_out%0d", tag, step), obs_outs, exp_outs(e));
      step++;
    end
  endtask

  task automatic check_idle(string tag);
    check({tag, "_db"}, {4'b0, obs_db}, 9'd0);
    check({tag, "_out"}, obs_outs, 9'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel = 1'b0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    {iniciar, tem_jogada, macro_valida, micro_valida, ganhou_micro} = '0;
    {micro_cheio, ganhou_macro, macro_cheio, proximo_livre} = '0;

    repeat (2) @(posedge clock);
    #1;
    check_idle("reset_a");
    @(negedge clock);
    rst_a = 1'b0;

    // tem_jogada alone does not leave INICIAL
    tem_jogada = 1'b1; push(0); drain("inicial_tem");
    // start: 0 -> 1 -> 2, zera for one cycle
    iniciar = 1'b1; push(1); push(2); drain("inicio");
    // iniciar mid-game ignored
    iniciar = 1'b1; push(2); drain("iniciar_meio");
    // invalid macro returns to ESPERA_MACRO
    macro_valida = 1'b0; tem_jogada = 1'b1; push_seq(3, 5); push(2); drain("macro_inv");
    // valid macro: jogar_micro on the 4th edge
    macro_valida = 1'b1; tem_jogada = 1'b1; push_seq(3, 6); drain("macro_ok");
    // invalid micro: no write, no swap
    micro_valida = 1'b0; tem_jogada = 1'b1; push_seq(7, 9); push(6); drain("micro_inv");
    // micro win, game continues, free macro choice
    micro_valida = 1'b1; ganhou_micro = 1'b1; ganhou_macro = 1'b0; proximo_livre = 1'b0;
    tem_jogada = 1'b1; push_seq(7, 16); push(2); drain("ganha_micro");
    // plain move, forced macro
    tem_jogada = 1'b1; push_seq(3, 6); drain("macro2");
    ganhou_micro = 1'b0; micro_cheio = 1'b0; proximo_livre = 1'b1;
    tem_jogada = 1'b1; push_seq(7, 12); push(16); push(6); drain("forcado");
    // micro and macro wins end the game
    ganhou_micro = 1'b1; ganhou_macro = 1'b1; proximo_livre = 1'b0;
    tem_jogada = 1'b1; push_seq(7, 15); push(17); drain("ganha_macro");
    tem_jogada = 1'b1; push(17); push(17); drain("fim_tem");
    iniciar = 1'b1; push(1); push(2); drain("reinicio");
    // draws on both boards also end the game
    ganhou_micro = 1'b0; ganhou_macro = 1'b0; micro_cheio = 1'b1; macro_cheio = 1'b1;
    tem_jogada = 1'b1; push_seq(3, 6); drain("macro3");
    tem_jogada = 1'b1; push_seq(7, 15); push(17); drain("empate");

    // MEM_LAT=3 instance
    rst_a = 1'b1;
    sel   = 1'b1;
    {micro_cheio, ganhou_macro, macro_cheio, proximo_livre, ganhou_micro} = '0;
    #1;
    check_idle("reset_b");
    @(negedge clock);
    rst_b = 1'b0;
    iniciar = 1'b1; push(1); push(2); drain("b_inicio");
    macro_valida = 1'b1; tem_jogada = 1'b1;
    push(3); push(4); push(4); push(4); push(5); push(6); drain("b_macro");
    micro_valida = 1'b1; tem_jogada = 1'b1;
    push(7); push(8); push(8); push(8); push(9); push(10); push(11); drain("b_micro");
    // reset while in LE_RES_MICRO: outputs drop with no clock edge
    #2;
    rst_b = 1'b1;
    #1;
    check_idle("b_reset_async");
    @(negedge clock);
    rst_b = 1'b0;
    tem_jogada = 1'b1; push(0); push(0); drain("b_pos_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
